// File: rtl/rc2014_bus_cycle_sync.sv
// RC2014 Z80 bus front-end: synchronises the strobes, decodes memory/I/O cycles and
// issues one valid/ack request per bus cycle, driving read data back until strobe release.
module rc2014_bus_cycle_sync #(
   parameter logic [15:0] MEM_BASE    = 16'h0000,
   parameter logic [16:0] MEM_SIZE    = 17'h02000,
   parameter logic [7:0]  IO_BASE     = 8'h40,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  TIMEOUT     = 8'd255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] A,
   input  logic [7:0]  D_IN,
   output logic [7:0]  D_OUT,
   output logic        D_OE,
   input  logic        MRQ,
   input  logic        IORQ,
   input  logic        RD,
   input  logic        WR,
   input  logic        M1,
   output logic        req_valid,
   output logic        req_write,
   output logic        req_io,
   output logic [15:0] req_addr,
   output logic [7:0]  req_wdata,
   input  logic        req_ack,
   input  logic [7:0]  rsp_rdata,
   output logic        err_timeout
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, IGNORE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  sync_q [SYNC_STAGES];
   logic        valid_q, valid_d;
   logic        write_q, write_d;
   logic        io_q, io_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  dout_q, dout_d;
   logic        doe_q, doe_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic s_mrq, s_iorq, s_rd, s_wr, s_m1;
   logic start, both_cmd, both_rw, released, hit, rd_active;
   logic [16:0] a_ext, win_lo, win_hi;

   // Strobe vector packed as {M1, WR, RD, IORQ, MRQ}; last stage feeds the FSM.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      end else begin
         sync_q[0] <= {M1, WR, RD, IORQ, MRQ};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign s_mrq  = sync_q[SYNC_STAGES-1][0];
   assign s_iorq = sync_q[SYNC_STAGES-1][1];
   assign s_rd   = sync_q[SYNC_STAGES-1][2];
   assign s_wr   = sync_q[SYNC_STAGES-1][3];
   assign s_m1   = sync_q[SYNC_STAGES-1][4];

   assign both_cmd = !s_mrq && !s_iorq;
   assign both_rw  = !s_rd && !s_wr;
   assign released = s_mrq && s_iorq && s_rd && s_wr;
   assign start    = (s_mrq ^ s_iorq) && (s_rd ^ s_wr) && s_m1;

   assign a_ext  = {1'b0, A};
   assign win_lo = {1'b0, MEM_BASE};
   assign win_hi = win_lo + MEM_SIZE;
   assign hit    = !s_iorq ? (A[7:0] == IO_BASE) : ((a_ext >= win_lo) && (a_ext < win_hi));

   assign rd_active = !s_rd && (io_q ? !s_iorq : !s_mrq);

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      write_d = write_q;
      io_d    = io_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      dout_d  = dout_q;
      doe_d   = doe_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (start && hit) begin
               state_d = REQ;
               addr_d  = A;
               wdata_d = D_IN;
               write_d = !s_wr;
               io_d    = !s_iorq;
               valid_d = 1'b1;
            end else if (start || both_cmd || both_rw) begin
               state_d = IGNORE;
            end
         end
         REQ: begin
            if (req_ack) begin
               state_d = HOLD;
               valid_d = 1'b0;
               cnt_d   = '0;
               if (!write_q && rd_active) begin
                  dout_d = rsp_rdata;
                  doe_d  = 1'b1;
               end
            end else if (cnt_q == TIMEOUT - 8'd1) begin
               // This cycle is the TIMEOUT-th one without ack.
               state_d = HOLD;
               valid_d = 1'b0;
               err_d   = 1'b1;
               cnt_d   = '0;
               if (!write_q && rd_active) begin
                  dout_d = 8'hFF;
                  doe_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if (released) begin
               state_d = IDLE;
               doe_d   = 1'b0;
            end
         end
         IGNORE: begin
            if (released) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         write_q <= 1'b0;
         io_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         doe_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         write_q <= write_d;
         io_q    <= io_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         dout_q  <= dout_d;
         doe_q   <= doe_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_valid   = valid_q;
   assign req_write   = write_q;
   assign req_io      = io_q;
   assign req_addr    = addr_q;
   assign req_wdata   = wdata_q;
   assign D_OUT       = dout_q;
   assign D_OE        = doe_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_rc2014_bus_cycle_sync.sv
// Directed and randomized bus cycles checked against a transaction-level model of the
// decode window, request latency, read-data hold and ack timeout.
module tb_rc2014_bus_cycle_sync;

   localparam int SYNC = 2;
   localparam int TO   = 255;

   logic        CLK, RST;
   logic [15:0] A;
   logic [7:0]  D_IN, D_OUT, rsp_rdata, req_wdata;
   logic        D_OE, MRQ, IORQ, RD, WR, M1;
   logic        req_valid, req_write, req_io, req_ack, err_timeout;
   logic [15:0] req_addr;

   int n_assert = 0;
   int n_fail   = 0;

   rc2014_bus_cycle_sync #(
      .MEM_BASE(16'h0000), .MEM_SIZE(17'h02000), .IO_BASE(8'h40),
      .SYNC_STAGES(SYNC), .TIMEOUT(8'd255)
   ) dut (
      .CLK(CLK), .RST(RST), .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
      .MRQ(MRQ), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1),
      .req_valid(req_valid), .req_write(req_write), .req_io(req_io),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
      .rsp_rdata(rsp_rdata), .err_timeout(err_timeout)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus(input logic mrq, input logic iorq, input logic rd, input logic wr, input logic m1);
      MRQ = mrq; IORQ = iorq; RD = rd; WR = wr; M1 = m1;
   endtask

   // Reference: a request is expected only for a normal (M1 high) cycle inside the window.
   function automatic bit model_hit(input bit io, input bit m1, input logic [15:0] a);
      int addr;
      addr = int'(a);
      if (!m1) return 1'b0;
      if (io) return (addr % 256) == 'h40;
      return (addr >= 'h0000) && (addr < 'h0000 + 'h2000);
   endfunction

   task automatic expect_none(input string tag);
      bit seen_v, seen_oe;
      seen_v = 0; seen_oe = 0;
      repeat (SYNC + 6) begin
         step();
         seen_v  |= (req_valid === 1'b1);
         seen_oe |= (D_OE === 1'b1);
      end
      chk({tag, "_no_req"}, 32'(seen_v), 32'(0));
      chk({tag, "_no_oe"}, 32'(seen_oe), 32'(0));
      bus(1, 1, 1, 1, 1);
      repeat (SYNC + 2) step();
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (req_valid !== 1'b1 && lat < SYNC + 8) begin
         step();
         lat++;
      end
   endtask

   task automatic run_cycle(input bit io, input bit wr, input bit m1, input logic [15:0] a,
                            input logic [7:0] din, input int ack_dly, input logic [7:0] rdata,
                            input bit early_rel);
      bit hit, exp_oe, bad;
      int lat, n;
      hit = model_hit(io, m1, a);
      A = a; D_IN = din;
      bus(io, !io, wr, !wr, m1);
      if (!hit) begin
         expect_none("miss");
         return;
      end
      wait_valid(lat);
      chk("req_latency", 32'(lat), 32'(SYNC + 1));
      if (req_valid !== 1'b1) begin
         bus(1, 1, 1, 1, 1);
         repeat (TO + SYNC + 4) step();
         return;
      end
      chk("req_io", 32'(req_io), 32'(io));
      chk("req_write", 32'(req_write), 32'(wr));
      chk("req_addr", 32'(req_addr), 32'(a));
      if (wr) chk("req_wdata", 32'(req_wdata), 32'(din));
      if (early_rel) begin
         bus(1, 1, 1, 1, 1);
         A = ~a; D_IN = ~din;
         repeat (SYNC + 2) step();
         chk("valid_held", 32'(req_valid), 32'(1));
         chk("addr_held", 32'(req_addr), 32'(a));
      end else begin
         repeat (ack_dly) step();
         chk("valid_before_ack", 32'(req_valid), 32'(1));
      end
      req_ack = 1'b1; rsp_rdata = rdata;
      step();
      req_ack = 1'b0; rsp_rdata = 8'($urandom);
      exp_oe = !wr && !early_rel;
      chk("valid_drop", 32'(req_valid), 32'(0));
      chk("oe_after_ack", 32'(D_OE), 32'(exp_oe));
      if (exp_oe) chk("dout_after_ack", 32'(D_OUT), 32'(rdata));
      if (!early_rel) begin
         bad = 0;
         repeat ($urandom_range(0, 3)) begin
            step();
            bad |= (D_OE !== exp_oe) || (req_valid !== 1'b0);
         end
         chk("hold_stable", 32'(bad), 32'(0));
         bus(1, 1, 1, 1, 1);
         if (exp_oe) begin
            n = 0;
            do begin
               step();
               n++;
            end while (D_OE === 1'b1 && n < 20);
            chk("oe_release_lat", 32'(n), 32'(SYNC + 1));
            chk("dout_kept", 32'(D_OUT), 32'(rdata));
         end
      end
      bad = 0;
      repeat (SYNC + 3) begin
         step();
         bad |= (req_valid !== 1'b0) || (D_OE !== 1'b0);
      end
      chk("single_req_idle", 32'(bad), 32'(0));
   endtask

   initial begin
      int lat, n;
      RST = 1'b1; req_ack = 1'b0; rsp_rdata = 8'h00; A = '0; D_IN = '0;
      bus(1, 1, 1, 1, 1);
      repeat (3) step();
      RST = 1'b0;
      step();
      chk("rst_valid", 32'(req_valid), 32'(0));
      chk("rst_oe", 32'(D_OE), 32'(0));
      chk("rst_dout", 32'(D_OUT), 32'(0));
      chk("rst_addr", 32'(req_addr), 32'(0));
      chk("rst_err", 32'(err_timeout), 32'(0));

      // Test-plan cycles
      run_cycle(0, 0, 1, 16'h0123, 8'h00, 3, 8'h5A, 0);
      run_cycle(1, 1, 1, 16'h1240, 8'hC3, 1, 8'h00, 0);
      run_cycle(0, 0, 1, 16'h2000, 8'h00, 0, 8'h11, 0);
      run_cycle(1, 0, 1, 16'h0041, 8'h00, 0, 8'h22, 0);
      run_cycle(0, 0, 1, 16'h1FFF, 8'h00, 0, 8'h3C, 0);
      run_cycle(0, 1, 1, 16'h0000, 8'h96, 2, 8'h00, 1);
      run_cycle(0, 0, 1, 16'h0200, 8'h00, 1, 8'h77, 1);

      // Interrupt acknowledge at the decoded port
      A = 16'h0040; bus(1, 0, 1, 1, 0);
      expect_none("intack");
      // Both command strobes or both direction strobes low
      A = 16'h0040; bus(0, 0, 0, 1, 1);
      expect_none("both_cmd");
      A = 16'h0010; bus(0, 1, 0, 0, 1);
      expect_none("both_rw");

      // Ack timeout on a read
      A = 16'h0100; bus(0, 1, 0, 1, 1);
      wait_valid(lat);
      chk("to_latency", 32'(lat), 32'(SYNC + 1));
      n = 0;
      while (req_valid === 1'b1 && n < TO + 20) begin
         chk("to_no_err_early", 32'(err_timeout), 32'(0));
         n++;
         step();
      end
      chk("to_req_cycles", 32'(n), 32'(TO));
      chk("to_err_pulse", 32'(err_timeout), 32'(1));
      chk("to_oe", 32'(D_OE), 32'(1));
      chk("to_dout", 32'(D_OUT), 32'(8'hFF));
      step();
      chk("to_err_single", 32'(err_timeout), 32'(0));
      chk("to_oe_held", 32'(D_OE), 32'(1));
      bus(1, 1, 1, 1, 1);
      n = 0;
      do begin
         step();
         n++;
      end while (D_OE === 1'b1 && n < 20);
      chk("to_release_lat", 32'(n), 32'(SYNC + 1));
      repeat (SYNC + 2) step();

      // Randomized cycles
      for (int i = 0; i < 40; i++) begin
         bit io, wr, m1;
         logic [15:0] a;
         io = 1'($urandom % 2);
         wr = 1'($urandom % 2);
         m1 = ($urandom % 8) != 0;
         case ($urandom % 4)
            0: a = 16'($urandom_range(0, 16'h1FFF));
            1: a = io ? {8'($urandom), 8'h40} : 16'h1FFF;
            2: a = io ? {8'($urandom), 8'h3F} : 16'h2000;
            default: a = 16'($urandom);
         endcase
         run_cycle(io, wr, m1, a, 8'($urandom), $urandom_range(0, 4), 8'($urandom),
                   ($urandom % 6) == 0);
      end

      // Reset while holding read data on the bus
      A = 16'h0055; bus(0, 1, 0, 1, 1);
      wait_valid(lat);
      req_ack = 1'b1; rsp_rdata = 8'hA5;
      step();
      req_ack = 1'b0;
      chk("pre_rst_oe", 32'(D_OE), 32'(1));
      #2 RST = 1'b1;
      #1;
      chk("async_rst_oe", 32'(D_OE), 32'(0));
      chk("async_rst_dout", 32'(D_OUT), 32'(0));
      step();
      RST = 1'b0;
      // Strobes still active after reset: treated as a fresh start
      wait_valid(lat);
      chk("post_rst_start_lat", 32'(lat), 32'(SYNC + 1));
      chk("post_rst_addr", 32'(req_addr), 32'(16'h0055));
      // Reset while in REQ, then release the bus under reset
      #2 RST = 1'b1;
      #1;
      chk("async_rst_valid", 32'(req_valid), 32'(0));
      chk("async_rst_addr", 32'(req_addr), 32'(0));
      bus(1, 1, 1, 1, 1);
      step();
      RST = 1'b0;
      n = 0;
      repeat (SYNC + 6) begin
         step();
         if (req_valid === 1'b1 || D_OE === 1'b1) n++;
      end
      chk("post_rst_idle", 32'(n), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
